// File: rtl/bus_ctrl_seq.sv
// bus_ctrl_seq: fetch/decode/(indirect)/execute sequencer that drives the CPU common-bus strobes.
// Optional macro INDIRECT_EN enables the indirect-address cycle T3 selected by ir[15].
module bus_ctrl_seq #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] ir,
  output logic [2:0]    sel,
  output logic [5:0]    load,
  output logic          pc_inc,
  output logic          mem_we,
  output logic [1:0]    alu_op,
  output logic          halted,
  output logic [2:0]    sc
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    E0   = 3'd5,
    E1   = 3'd6,
    HALT = 3'd7
  } state_t;

  typedef struct packed {
    logic [2:0] sel;
    logic [5:0] load;
    logic       pc_inc;
    logic       mem_we;
    logic [1:0] alu_op;
    logic       halted;
  } strobes_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_AR   = 3'b001;
  localparam logic [2:0] SEL_PC   = 3'b010;
  localparam logic [2:0] SEL_AC   = 3'b100;
  localparam logic [2:0] SEL_MEM  = 3'b101;
  localparam logic [2:0] SEL_IR   = 3'b110;

  localparam logic [2:0] OPC_LDA = 3'b000;
  localparam logic [2:0] OPC_STA = 3'b010;
  localparam logic [2:0] OPC_BUN = 3'b011;
  localparam logic [2:0] OPC_HLT = 3'b111;

  state_t     state, state_nxt;
  logic [2:0] opc, opc_nxt;
  logic       ind, ind_nxt;
  logic       ind_take;
  strobes_t   strb;

`ifdef INDIRECT_EN
  assign ind_take = ir[DW-1];
`else
  assign ind_take = 1'b0;
`endif

  // Address field and indirect flag feed the register file, not the sequencer's decisions.
  logic unused_bits;
  assign unused_bits = ^{ir[DW-5:AW], ir[AW-1:0], ind};

  // Strobes are a pure decode of (state, opcode); computing them from the next state
  // lets them be registered yet still line up with the state they belong to.
  function automatic strobes_t decode(input state_t st, input logic [2:0] op);
    strobes_t s;
    s = '0;
    case (st)
      T0: begin s.sel = SEL_PC;  s.load[0] = 1'b1; end
      T1: begin s.sel = SEL_MEM; s.load[4] = 1'b1; s.pc_inc = 1'b1; end
      T2: begin s.sel = SEL_IR;  s.load[0] = 1'b1; end
      T3: begin s.sel = SEL_MEM; s.load[0] = 1'b1; end
      E0: begin
        case (op)
          OPC_STA: begin s.sel = SEL_AC; s.mem_we = 1'b1; end
          OPC_BUN: begin s.sel = SEL_AR; s.load[1] = 1'b1; end
          default: begin s.sel = SEL_MEM; s.load[2] = 1'b1; end
        endcase
      end
      E1: begin
        s.sel     = SEL_NONE;
        s.load[3] = 1'b1;
        s.alu_op  = (op == OPC_LDA) ? 2'b00 : 2'b01;
      end
      HALT:    s.halted = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  always_comb begin
    state_nxt = state;
    opc_nxt   = opc;
    ind_nxt   = ind;
    case (state)
      IDLE: if (start) state_nxt = T0;
      T0:   state_nxt = T1;
      T1:   state_nxt = T2;
      T2: begin
        opc_nxt = ir[DW-2:DW-4];
        ind_nxt = ir[DW-1];
        if (!ir[DW-2])                          state_nxt = ind_take ? T3 : E0;
        else if (ir[DW-2:DW-4] == OPC_HLT)      state_nxt = HALT;
        else                                    state_nxt = T0;
      end
      T3:   state_nxt = E0;
      E0:   state_nxt = opc[1] ? T0 : E1;
      E1:   state_nxt = T0;
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      opc   <= '0;
      ind   <= 1'b0;
      strb  <= '0;
    end else begin
      state <= state_nxt;
      opc   <= opc_nxt;
      ind   <= ind_nxt;
      strb  <= decode(state_nxt, opc_nxt);
    end
  end

  assign sel    = strb.sel;
  assign load   = strb.load;
  assign pc_inc = strb.pc_inc;
  assign mem_we = strb.mem_we;
  assign alu_op = strb.alu_op;
  assign halted = strb.halted;
  assign sc     = state;

endmodule

// File: tb/tb_bus_ctrl_seq.sv
// Directed bench for bus_ctrl_seq: a small register file / sram model follows the strobes
// so instruction results (AC, PC, memory) can be compared against hand-computed values.
module tb_bus_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ir_r;
  logic [2:0]  sel;
  logic [5:0]  load;
  logic        pc_inc, mem_we, halted;
  logic [1:0]  alu_op;
  logic [2:0]  sc;

  logic [7:0]  ar, pc;
  logic [15:0] dr, ac, bus;
  logic [15:0] mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_ctrl_seq #(.AW(8), .DW(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir_r),
    .sel(sel), .load(load), .pc_inc(pc_inc), .mem_we(mem_we),
    .alu_op(alu_op), .halted(halted), .sc(sc)
  );

  always_comb begin
    bus = '0;
    case (sel)
      3'b001:  bus = {8'h00, ar};
      3'b010:  bus = {8'h00, pc};
      3'b011:  bus = dr;
      3'b100:  bus = ac;
      3'b101:  bus = mem[ar];
      3'b110:  bus = ir_r;
      default: bus = '0;
    endcase
  end

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (!rst) begin
      ar <= '0; pc <= '0; dr <= '0; ac <= '0; ir_r <= '0;
    end else begin
      if (load[0]) ar <= bus[7:0];
      if (pc_inc) pc <= pc + 8'd1;
      else if (load[1]) pc <= bus[7:0];
      if (load[2]) dr <= bus;
      if (load[3]) ac <= (alu_op == 2'b01) ? ac + dr : dr;
      if (load[4]) ir_r <= bus;
      if (mem_we) mem[ar] <= bus;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock, then compare state code, bus select, load and {pc_inc,mem_we,alu_op,halted}.
  task automatic cyc(input string tag, input logic [2:0] esc, input logic [2:0] esel,
                     input logic [5:0] eload, input logic [4:0] emisc);
    step();
    chk({tag, ".sc"}, 32'(sc), 32'(esc));
    chk({tag, ".sel"}, 32'(sel), 32'(esel));
    chk({tag, ".load"}, 32'(load), 32'(eload));
    chk({tag, ".misc"}, 32'({pc_inc, mem_we, alu_op, halted}), 32'(emisc));
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    rst = 1'b0;
    step(); step();
    chk("rst.sc", 32'(sc), 0);
    chk("rst.halted", 32'(halted), 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle.sc", 32'(sc), 0);
      chk("idle.sel", 32'(sel), 0);
      chk("idle.load", 32'(load), 0);
    end

    poke(8'd0, 16'h0010); poke(8'd16, 16'h0005);
    poke(8'd1, 16'h1011); poke(8'd17, 16'h0003);
    poke(8'd2, 16'h2020); poke(8'd3, 16'h3000);
    chk("idle2.sc", 32'(sc), 0);

    // LDA 16
    start = 1'b1;
    cyc("lda.t0", 3'd1, 3'b010, 6'b000001, 5'b00000);
    start = 1'b0;
    cyc("lda.t1", 3'd2, 3'b101, 6'b010000, 5'b10000);
    cyc("lda.t2", 3'd3, 3'b110, 6'b000001, 5'b00000);
    cyc("lda.e0", 3'd5, 3'b101, 6'b000100, 5'b00000);
    cyc("lda.e1", 3'd6, 3'b000, 6'b001000, 5'b00000);

    // ADD 17
    cyc("add.t0", 3'd1, 3'b010, 6'b000001, 5'b00000);
    chk("lda.ac", 32'(ac), 32'h0005);
    cyc("add.t1", 3'd2, 3'b101, 6'b010000, 5'b10000);
    cyc("add.t2", 3'd3, 3'b110, 6'b000001, 5'b00000);
    cyc("add.e0", 3'd5, 3'b101, 6'b000100, 5'b00000);
    cyc("add.e1", 3'd6, 3'b000, 6'b001000, 5'b00010);

    // STA 32; HLT is planted at address 0 for the BUN that follows
    pre_we = 1'b1; pre_addr = 8'd0; pre_data = 16'h7000;
    cyc("sta.t0", 3'd1, 3'b010, 6'b000001, 5'b00000);
    pre_we = 1'b0;
    chk("add.ac", 32'(ac), 32'h0008);
    cyc("sta.t1", 3'd2, 3'b101, 6'b010000, 5'b10000);
    cyc("sta.t2", 3'd3, 3'b110, 6'b000001, 5'b00000);
    cyc("sta.e0", 3'd5, 3'b100, 6'b000000, 5'b01000);

    // BUN 0
    cyc("bun.t0", 3'd1, 3'b010, 6'b000001, 5'b00000);
    chk("sta.mem32", 32'(mem[32]), 32'h0008);
    cyc("bun.t1", 3'd2, 3'b101, 6'b010000, 5'b10000);
    cyc("bun.t2", 3'd3, 3'b110, 6'b000001, 5'b00000);
    cyc("bun.e0", 3'd5, 3'b001, 6'b000010, 5'b00000);

    // HLT at address 0
    cyc("hlt.t0", 3'd1, 3'b010, 6'b000001, 5'b00000);
    chk("bun.pc", 32'(pc), 0);
    cyc("hlt.t1", 3'd2, 3'b101, 6'b010000, 5'b10000);
    cyc("hlt.t2", 3'd3, 3'b110, 6'b000001, 5'b00000);
    cyc("hlt.h", 3'd7, 3'b000, 6'b000000, 5'b00001);
    start = 1'b1;
    step(); step(); step();
    chk("hlt.start_ignored.sc", 32'(sc), 7);
    chk("hlt.start_ignored.halted", 32'(halted), 1);
    start = 1'b0;
    rst = 1'b0;
    step();
    chk("hlt.rst.sc", 32'(sc), 0);
    chk("hlt.rst.halted", 32'(halted), 0);
    rst = 1'b1;

    // Indirect LDA through M[64]
    poke(8'd0, 16'h8040); poke(8'd64, 16'h0050); poke(8'd80, 16'h0009);
    start = 1'b1;
    cyc("ind.t0", 3'd1, 3'b010, 6'b000001, 5'b00000);
    start = 1'b0;
    cyc("ind.t1", 3'd2, 3'b101, 6'b010000, 5'b10000);
    cyc("ind.t2", 3'd3, 3'b110, 6'b000001, 5'b00000);
`ifdef INDIRECT_EN
    cyc("ind.t3", 3'd4, 3'b101, 6'b000001, 5'b00000);
`endif
    cyc("ind.e0", 3'd5, 3'b101, 6'b000100, 5'b00000);
    cyc("ind.e1", 3'd6, 3'b000, 6'b001000, 5'b00000);
    cyc("next.t0", 3'd1, 3'b010, 6'b000001, 5'b00000);
`ifdef INDIRECT_EN
    chk("ind.ac", 32'(ac), 32'h0009);
`else
    chk("ind.ac", 32'(ac), 32'h0050);
`endif

    // Reset in the middle of a fetch abandons it
    cyc("next.t1", 3'd2, 3'b101, 6'b010000, 5'b10000);
    rst = 1'b0;
    step();
    chk("midrst.sc", 32'(sc), 0);
    chk("midrst.load", 32'(load), 0);
    chk("midrst.sel", 32'(sel), 0);
    chk("midrst.pc_inc", 32'(pc_inc), 0);
    rst = 1'b1;
    step();
    chk("midrst.idle.sc", 32'(sc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
